mips_multicycle_ctrl: RTL and testbench

- Multicycle control FSM sequencing the MIPS CPU datapath: fetch, decode, execute, memory and writeback.
- Decodes the latched instruction opcode/funct into ALU operation, operand selects, immediate selection and write strobes.
- Waits on a memory-ready handshake, bounded by a timeout.
- Sits beside the datapath in CPU; State and AluOp feed the existing t_State / t_AluOp debug ports.

---
 rtl/mips_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the latched opcode/funct into datapath selects and write strobes.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic [3:0] State,
   output logic [3:0] AluOp,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [1:0] ImmedSel,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] PCSource,
   output logic [1:0] RegDst,
   output logic       MemtoReg,
   output logic       Fault
);

   localparam int unsigned OP_W  = 6;
   localparam int unsigned ALU_W = 4;
   localparam int unsigned ST_W  = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
   localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
   localparam logic [ALU_W-1:0] ALU_XOR = 4'd4;
   localparam logic [ALU_W-1:0] ALU_NOR = 4'd5;
   localparam logic [ALU_W-1:0] ALU_SLT = 4'd6;
   localparam logic [ALU_W-1:0] ALU_SLL = 4'd7;
   localparam logic [ALU_W-1:0] ALU_SRL = 4'd8;
   localparam logic [ALU_W-1:0] ALU_LUI = 4'd9;

   typedef enum logic [ST_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_RWB      = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_JAL      = 4'd10,
      S_EXEC_I   = 4'd11,
      S_IWB      = 4'd12,
      S_FAULT    = 4'd15
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q;
   logic             mem_wait;
   logic             mem_rd, mem_wr, ir_wr, pc_wr, reg_wr;

   // State, wait counter and sticky fault flag
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_q | (state_d == S_FAULT);
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      mem_wait = 1'b0;
      AluOp    = ALU_ADD;
      AluSrcA  = 1'b0;
      AluSrcB  = 2'd0;
      ImmedSel = 2'd0;
      IorD     = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      reg_wr   = 1'b0;
      PCSource = 2'd0;
      RegDst   = 2'd0;
      MemtoReg = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_rd   = 1'b1;
            AluSrcB  = 2'd1;
            mem_wait = 1'b1;
            if (MemReady) begin
               ir_wr   = 1'b1;
               pc_wr   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            AluSrcB  = 2'd2;
            ImmedSel = 2'd2;
            case (Opcode)
               OP_RTYPE:                                   state_d = S_EXEC_R;
               OP_LW, OP_SW:                               state_d = S_MEMADDR;
               OP_BEQ, OP_BNE:                             state_d = S_BRANCH;
               OP_J:                                       state_d = S_JUMP;
               OP_JAL:                                     state_d = S_JAL;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_EXEC_I;
               default:                                    state_d = S_FAULT;
            endcase
         end
         S_MEMADDR: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'd2;
            state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_rd   = 1'b1;
            IorD     = 1'b1;
            mem_wait = 1'b1;
            if (MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_wr   = 1'b1;
            MemtoReg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_wr   = 1'b1;
            IorD     = 1'b1;
            mem_wait = 1'b1;
            if (MemReady) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            AluSrcA = 1'b1;
            state_d = S_RWB;
            case (Funct)
               6'h20, 6'h21: AluOp = ALU_ADD;
               6'h22, 6'h23: AluOp = ALU_SUB;
               6'h24:        AluOp = ALU_AND;
               6'h25:        AluOp = ALU_OR;
               6'h26:        AluOp = ALU_XOR;
               6'h27:        AluOp = ALU_NOR;
               6'h2A:        AluOp = ALU_SLT;
               6'h00:        AluOp = ALU_SLL;
               6'h02:        AluOp = ALU_SRL;
               default:      state_d = S_FAULT;
            endcase
         end
         S_RWB: begin
            reg_wr  = 1'b1;
            RegDst  = 2'd1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            AluSrcA  = 1'b1;
            AluOp    = ALU_SUB;
            PCSource = 2'd1;
            pc_wr    = (Opcode == OP_BEQ) ? Zero : ~Zero;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            PCSource = 2'd2;
            pc_wr    = 1'b1;
            state_d  = S_FETCH;
         end
         S_JAL: begin
            reg_wr   = 1'b1;
            RegDst   = 2'd2;
            PCSource = 2'd2;
            pc_wr    = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXEC_I: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'd2;
            state_d = S_IWB;
            case (Opcode)
               OP_ADDI: AluOp = ALU_ADD;
               OP_SLTI: AluOp = ALU_SLT;
               OP_ANDI: begin AluOp = ALU_AND; ImmedSel = 2'd1; end
               OP_ORI:  begin AluOp = ALU_OR;  ImmedSel = 2'd1; end
               OP_LUI:  begin AluOp = ALU_LUI; ImmedSel = 2'd3; end
               default: state_d = S_FAULT;
            endcase
         end
         S_IWB: begin
            reg_wr  = 1'b1;
            state_d = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase

      // A completing access wins over the timeout on the same cycle
      if (mem_wait && !MemReady) begin
         if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d = S_FAULT;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Strobes are suppressed while reset is held so an interrupted access issues nothing
   assign MemRead  = mem_rd & ~Reset;
   assign MemWrite = mem_wr & ~Reset;
   assign IRWrite  = ir_wr  & ~Reset;
   assign PCWrite  = pc_wr  & ~Reset;
   assign RegWrite = reg_wr & ~Reset;
   assign State    = state_q;
   assign Fault    = fault_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level expected-cycle plan.
module tb_mips_multicycle_ctrl;

   localparam int unsigned TO = 15;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] Opcode = 6'h00;
   logic [5:0] Funct = 6'h20;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic [3:0] State, AluOp;
   logic       AluSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, MemtoReg, Fault;
   logic [1:0] AluSrcB, ImmedSel, PCSource, RegDst;

   int n_cmp = 0;
   int n_err = 0;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .MemReady(MemReady), .State(State), .AluOp(AluOp), .AluSrcA(AluSrcA),
      .AluSrcB(AluSrcB), .ImmedSel(ImmedSel), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg), .Fault(Fault)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0] state;
      logic [3:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] immedsel;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       pcwrite;
      logic       regwrite;
      logic [1:0] pcsource;
      logic [1:0] regdst;
      logic       memtoreg;
      logic       fault;
   } outs_t;

   typedef struct packed {
      outs_t o;
      logic  mr;
      logic  z;
   } step_t;

   outs_t obs;
   assign obs = {State, AluOp, AluSrcA, AluSrcB, ImmedSel, IorD, MemRead, MemWrite,
                 IRWrite, PCWrite, RegWrite, PCSource, RegDst, MemtoReg, Fault};

   logic [4:0] strobes;
   assign strobes = {MemRead, MemWrite, IRWrite, PCWrite, RegWrite};

   step_t plan_q[$];

   // ---------------- reference model: expected cycles per instruction ----------------
   function automatic outs_t blank(input logic [3:0] st);
      outs_t o;
      o = '0;
      o.state = st;
      return o;
   endfunction

   function automatic int r_alu(input logic [5:0] fn);
      case (fn)
         6'h20, 6'h21: return 0;
         6'h22, 6'h23: return 1;
         6'h24: return 2;
         6'h25: return 3;
         6'h26: return 4;
         6'h27: return 5;
         6'h2A: return 6;
         6'h00: return 7;
         6'h02: return 8;
         default: return -1;
      endcase
   endfunction

   task automatic add_step(input outs_t o, input logic z);
      step_t s;
      s.o  = o;
      s.mr = 1'($urandom);
      s.z  = z;
      plan_q.push_back(s);
   endtask

   // kind 0 = instruction fetch, 1 = data read, 2 = data write
   task automatic add_mem(input int kind, input int waits);
      for (int i = 0; i <= waits; i++) begin
         step_t s;
         s.mr = (i == waits);
         s.z  = 1'($urandom);
         if (kind == 0) begin
            s.o = blank(4'd0);
            s.o.memread = 1'b1;
            s.o.alusrcb = 2'd1;
            s.o.irwrite = s.mr;
            s.o.pcwrite = s.mr;
         end else if (kind == 1) begin
            s.o = blank(4'd3);
            s.o.memread = 1'b1;
            s.o.iord    = 1'b1;
         end else begin
            s.o = blank(4'd5);
            s.o.memwrite = 1'b1;
            s.o.iord     = 1'b1;
         end
         plan_q.push_back(s);
      end
   endtask

   function automatic int pick_waits();
      return ($urandom_range(0, 7) == 0) ? int'(TO - 1) : int'($urandom_range(0, 3));
   endfunction

   task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn);
      outs_t o;
      logic  z;
      add_mem(0, pick_waits());
      o = blank(4'd1); o.alusrcb = 2'd2; o.immedsel = 2'd2;
      add_step(o, 1'($urandom));
      case (op)
         6'h00: begin
            o = blank(4'd6); o.alusrca = 1'b1; o.aluop = 4'(r_alu(fn));
            add_step(o, 1'($urandom));
            o = blank(4'd7); o.regwrite = 1'b1; o.regdst = 2'd1;
            add_step(o, 1'($urandom));
         end
         6'h23, 6'h2B: begin
            o = blank(4'd2); o.alusrca = 1'b1; o.alusrcb = 2'd2;
            add_step(o, 1'($urandom));
            if (op == 6'h23) begin
               add_mem(1, pick_waits());
               o = blank(4'd4); o.regwrite = 1'b1; o.memtoreg = 1'b1;
               add_step(o, 1'($urandom));
            end else begin
               add_mem(2, pick_waits());
            end
         end
         6'h04, 6'h05: begin
            z = 1'($urandom);
            o = blank(4'd8); o.alusrca = 1'b1; o.aluop = 4'd1; o.pcsource = 2'd1;
            o.pcwrite = (op == 6'h04) ? z : ~z;
            add_step(o, z);
         end
         6'h02: begin
            o = blank(4'd9); o.pcsource = 2'd2; o.pcwrite = 1'b1;
            add_step(o, 1'($urandom));
         end
         6'h03: begin
            o = blank(4'd10); o.regwrite = 1'b1; o.regdst = 2'd2;
            o.pcsource = 2'd2; o.pcwrite = 1'b1;
            add_step(o, 1'($urandom));
         end
         default: begin
            o = blank(4'd11); o.alusrca = 1'b1; o.alusrcb = 2'd2;
            case (op)
               6'h08: begin o.aluop = 4'd0; o.immedsel = 2'd0; end
               6'h0A: begin o.aluop = 4'd6; o.immedsel = 2'd0; end
               6'h0C: begin o.aluop = 4'd2; o.immedsel = 2'd1; end
               6'h0D: begin o.aluop = 4'd3; o.immedsel = 2'd1; end
               default: begin o.aluop = 4'd9; o.immedsel = 2'd3; end
            endcase
            add_step(o, 1'($urandom));
            o = blank(4'd12); o.regwrite = 1'b1;
            add_step(o, 1'($urandom));
         end
      endcase
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 12))
         0, 1: return 6'h00;
         2:  return 6'h23;
         3:  return 6'h2B;
         4:  return 6'h04;
         5:  return 6'h05;
         6:  return 6'h02;
         7:  return 6'h03;
         8:  return 6'h08;
         9:  return 6'h0A;
         10: return 6'h0C;
         11: return 6'h0D;
         default: return 6'h0F;
      endcase
   endfunction

   function automatic logic [5:0] pick_fn();
      case ($urandom_range(0, 10))
         0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
         4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
         8: return 6'h2A;  9: return 6'h00;  default: return 6'h02;
      endcase
   endfunction

   // Leaves the DUT in the first FETCH cycle; the next negedge samples it
   task automatic do_reset();
      @(negedge Clk); Reset = 1'b1; MemReady = 1'b0;
      @(posedge Clk); #1; Reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge Clk); Reset = 1'b1; MemReady = 1'b1; Opcode = 6'h00; Funct = 6'h20; #1;
      n_cmp++; if (strobes !== 5'b0) begin n_err++; $display("FAIL reset_strobes_pre got=%b exp=00000", strobes); end
      @(posedge Clk); #1;
      n_cmp++; if (State !== 4'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", State); end
      n_cmp++; if (Fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", Fault); end
      n_cmp++; if (strobes !== 5'b0) begin n_err++; $display("FAIL reset_strobes_held got=%b exp=00000", strobes); end
      Reset = 1'b0; #1;
      n_cmp++; if ({MemRead, IRWrite, PCWrite, IorD} !== 4'b1110) begin
         n_err++; $display("FAIL reset_release_fetch got=%b exp=1110", {MemRead, IRWrite, PCWrite, IorD}); end
   endtask

   task automatic test_rtype();
      int exp_st[5] = '{0, 1, 6, 7, 0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk); Opcode = 6'h00; Funct = 6'h20; MemReady = 1'b1; Zero = 1'($urandom); #1;
         n_cmp++; if (State !== 4'(exp_st[i])) begin n_err++; $display("FAIL rtype_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]); end
         n_cmp++; if (RegWrite !== (i == 3)) begin n_err++; $display("FAIL rtype_regwrite cyc=%0d got=%b", i, RegWrite); end
         if (i == 2) begin
            n_cmp++; if ({AluOp, AluSrcA, AluSrcB} !== 7'b0000_1_00) begin
               n_err++; $display("FAIL rtype_exec got=%b exp=0000100", {AluOp, AluSrcA, AluSrcB}); end
         end
         if (i == 3) begin
            n_cmp++; if ({RegDst, MemtoReg} !== 3'b010) begin n_err++; $display("FAIL rtype_rwb got=%b exp=010", {RegDst, MemtoReg}); end
         end
      end
   endtask

   task automatic test_lw_wait();
      int   exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
      logic mr[9]     = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge Clk); Opcode = 6'h23; MemReady = mr[i]; #1;
         n_cmp++; if (State !== 4'(exp_st[i])) begin n_err++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]); end
         n_cmp++; if (Fault !== 1'b0) begin n_err++; $display("FAIL lw_fault cyc=%0d got=%b exp=0", i, Fault); end
         if (i >= 3 && i <= 6) begin
            n_cmp++; if ({MemRead, IorD, RegWrite} !== 3'b110) begin n_err++; $display("FAIL lw_memread cyc=%0d got=%b exp=110", i, {MemRead, IorD, RegWrite}); end
         end
         if (i == 7) begin
            n_cmp++; if ({RegWrite, MemtoReg, RegDst} !== 4'b1100) begin n_err++; $display("FAIL lw_memwb got=%b exp=1100", {RegWrite, MemtoReg, RegDst}); end
         end
      end
      // abort a pending read with reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk); Opcode = 6'h23; MemReady = (i < 3); #1;
      end
      n_cmp++; if (State !== 4'd3) begin n_err++; $display("FAIL lw_abort_pre got=%0d exp=3", State); end
      @(negedge Clk); Reset = 1'b1; MemReady = 1'b1; #1;
      n_cmp++; if (strobes !== 5'b0) begin n_err++; $display("FAIL lw_abort_strobes got=%b exp=00000", strobes); end
      @(posedge Clk); #1;
      n_cmp++; if (State !== 4'd0) begin n_err++; $display("FAIL lw_abort_state got=%0d exp=0", State); end
      Reset = 1'b0;
   endtask

   task automatic test_branch();
      int exp_st[3] = '{0, 1, 8};
      logic [5:0] op;
      do_reset();
      for (int b = 0; b < 2; b++) begin
         op = (b == 0) ? 6'h04 : 6'h05;
         for (int i = 0; i < 3; i++) begin
            @(negedge Clk); Opcode = op; MemReady = 1'b1; Zero = 1'b1; #1;
            n_cmp++; if (State !== 4'(exp_st[i])) begin n_err++; $display("FAIL branch_state op=%h cyc=%0d got=%0d exp=%0d", op, i, State, exp_st[i]); end
         end
         n_cmp++; if (PCWrite !== (op == 6'h04)) begin n_err++; $display("FAIL branch_zero1 op=%h got=%b", op, PCWrite); end
         n_cmp++; if ({PCSource, AluOp, AluSrcA} !== 7'b01_0001_1) begin n_err++; $display("FAIL branch_sel op=%h got=%b exp=0100011", op, {PCSource, AluOp, AluSrcA}); end
         Zero = 1'b0; #1;
         n_cmp++; if (PCWrite !== (op == 6'h05)) begin n_err++; $display("FAIL branch_zero0 op=%h got=%b", op, PCWrite); end
      end
      @(negedge Clk); #1;
      n_cmp++; if (State !== 4'd0) begin n_err++; $display("FAIL branch_return got=%0d exp=0", State); end
   endtask

   task automatic test_illegal();
      int exp_st[4] = '{0, 1, 6, 15};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk); Opcode = 6'h3F; MemReady = 1'b1; #1;
      end
      n_cmp++; if ({State, Fault} !== 5'b0001_0) begin n_err++; $display("FAIL illegal_decode got=%b exp=00010", {State, Fault}); end
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk); MemReady = 1'($urandom); Zero = 1'($urandom); #1;
         n_cmp++; if ({State, Fault, strobes} !== 10'b1111_1_00000) begin
            n_err++; $display("FAIL illegal_hold cyc=%0d got=%b exp=1111100000", i, {State, Fault, strobes}); end
      end
      @(negedge Clk); Reset = 1'b1;
      @(posedge Clk); #1;
      n_cmp++; if ({State, Fault} !== 5'b0000_0) begin n_err++; $display("FAIL illegal_recover got=%b exp=00000", {State, Fault}); end
      Reset = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk); Opcode = 6'h00; Funct = 6'h3F; MemReady = 1'b1; #1;
         n_cmp++; if (State !== 4'(exp_st[i])) begin n_err++; $display("FAIL bad_funct_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]); end
      end
      n_cmp++; if (Fault !== 1'b1) begin n_err++; $display("FAIL bad_funct_fault got=%b exp=1", Fault); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= int'(TO); i++) begin
         @(negedge Clk); MemReady = 1'b0; #1;
         n_cmp++; if ({State, MemRead, IRWrite} !== 6'b0000_10) begin n_err++; $display("FAIL fetch_wait cyc=%0d got=%b exp=000010", i, {State, MemRead, IRWrite}); end
      end
      @(negedge Clk); #1;
      n_cmp++; if ({State, Fault} !== 5'b1111_1) begin n_err++; $display("FAIL fetch_timeout got=%b exp=11111", {State, Fault}); end
      do_reset();
      for (int i = 1; i <= int'(TO); i++) begin
         @(negedge Clk); MemReady = (i == int'(TO)); #1;
      end
      n_cmp++; if ({State, IRWrite, PCWrite} !== 6'b0000_11) begin n_err++; $display("FAIL fetch_last_ready got=%b exp=000011", {State, IRWrite, PCWrite}); end
      @(negedge Clk); #1;
      n_cmp++; if ({State, Fault} !== 5'b0001_0) begin n_err++; $display("FAIL fetch_last_decode got=%b exp=00010", {State, Fault}); end
      do_reset();
      for (int i = 0; i < 3 + int'(TO); i++) begin
         @(negedge Clk); Opcode = 6'h2B; MemReady = (i == 0); #1;
      end
      n_cmp++; if ({State, MemWrite} !== 5'b0101_1) begin n_err++; $display("FAIL sw_wait got=%b exp=01011", {State, MemWrite}); end
      @(negedge Clk); #1;
      n_cmp++; if ({State, Fault, strobes} !== 10'b1111_1_00000) begin n_err++; $display("FAIL sw_timeout got=%b exp=1111100000", {State, Fault, strobes}); end
   endtask

   task automatic test_ori();
      int exp_st[5] = '{0, 1, 11, 12, 0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk); Opcode = 6'h0D; Funct = 6'($urandom); MemReady = 1'b1; #1;
         n_cmp++; if (State !== 4'(exp_st[i])) begin n_err++; $display("FAIL ori_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]); end
         if (i == 2) begin
            n_cmp++; if ({ImmedSel, AluOp, AluSrcB, AluSrcA, RegWrite} !== 10'b01_0011_10_1_0) begin
               n_err++; $display("FAIL ori_exec got=%b exp=0100111010", {ImmedSel, AluOp, AluSrcB, AluSrcA, RegWrite}); end
         end
         if (i == 3) begin
            n_cmp++; if ({RegWrite, RegDst, MemtoReg} !== 4'b1000) begin n_err++; $display("FAIL ori_iwb got=%b exp=1000", {RegWrite, RegDst, MemtoReg}); end
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] op, fn;
      step_t      s;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         op = pick_op();
         fn = (op == 6'h00) ? pick_fn() : 6'($urandom);
         plan_q.delete();
         plan_instr(op, fn);
         while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            @(negedge Clk); Opcode = op; Funct = fn; MemReady = s.mr; Zero = s.z; #1;
            n_cmp++;
            if (obs !== s.o) begin
               n_err++;
               $display("FAIL random instr=%0d op=%h fn=%h got=%h exp=%h", n, op, fn, obs, s.o);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_illegal();
      test_timeout();
      test_ori();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
